// File: rtl/ci_issue_controller.sv
// Custom-instruction bus initiator: accepts one request, issues a single start
// pulse, waits for done or timeout, and returns result and latency through a
// valid/ready response channel. One request outstanding at a time.
module ci_issue_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned LAT_WIDTH      = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [7:0]           req_ciN,
  input  logic [31:0]          req_valueA,
  input  logic [31:0]          req_valueB,
  output logic                 ciStart,
  output logic [7:0]           ciN,
  output logic [31:0]          ciValueA,
  output logic [31:0]          ciValueB,
  input  logic                 ciDone,
  input  logic [31:0]          ciResult,
  output logic                 ciBusy,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_result,
  output logic                 resp_timeout,
  output logic [LAT_WIDTH-1:0] resp_latency,
  output logic                 err_stray
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [LAT_WIDTH-1:0] TIMEOUT_VAL = LAT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [LAT_WIDTH-1:0] CNT_ONE     = LAT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [7:0]           ci_n_q, ci_n_d;
  logic [31:0]          ci_a_q, ci_a_d;
  logic [31:0]          ci_b_q, ci_b_d;
  logic [LAT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          result_q, result_d;
  logic                 timeout_q, timeout_d;
  logic [LAT_WIDTH-1:0] latency_q, latency_d;
  logic                 stray_q, stray_d;
  logic                 req_ready_q, req_ready_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic                 resp_valid_q, resp_valid_d;

  // Next-state, capture and registered-output decode.
  // The operand registers double as the ci* bus drivers: loaded on accept,
  // cleared whenever the next state is outside ISSUE/WAIT.
  always_comb begin
    state_d   = state_q;
    ci_n_d    = ci_n_q;
    ci_a_d    = ci_a_q;
    ci_b_d    = ci_b_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    latency_d = latency_q;
    stray_d   = stray_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          ci_n_d  = req_ciN;
          ci_a_d  = req_valueA;
          ci_b_d  = req_valueB;
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ciDone) begin
          result_d  = ciResult;
          latency_d = '0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_RESP;
        end else begin
          cnt_d   = CNT_ONE;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ciDone) begin
          result_d  = ciResult;
          latency_d = cnt_q;
          timeout_d = 1'b0;
          state_d   = S_RESP;
        end else if (cnt_q == TIMEOUT_VAL) begin
          result_d  = '0;
          latency_d = TIMEOUT_VAL;
          timeout_d = 1'b1;
          state_d   = S_RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          result_d  = '0;
          timeout_d = 1'b0;
          latency_d = '0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_IDLE || state_q == S_RESP) && ciDone) begin
      stray_d = 1'b1;
    end

    if (state_d != S_ISSUE && state_d != S_WAIT) begin
      ci_n_d = '0;
      ci_a_d = '0;
      ci_b_d = '0;
    end

    req_ready_d  = (state_d == S_IDLE);
    start_d      = (state_d == S_ISSUE);
    busy_d       = (state_d != S_IDLE);
    resp_valid_d = (state_d == S_RESP);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ci_n_q       <= '0;
      ci_a_q       <= '0;
      ci_b_q       <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
      timeout_q    <= 1'b0;
      latency_q    <= '0;
      stray_q      <= 1'b0;
      req_ready_q  <= 1'b1;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ci_n_q       <= ci_n_d;
      ci_a_q       <= ci_a_d;
      ci_b_q       <= ci_b_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      timeout_q    <= timeout_d;
      latency_q    <= latency_d;
      stray_q      <= stray_d;
      req_ready_q  <= req_ready_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign ciStart      = start_q;
  assign ciN          = ci_n_q;
  assign ciValueA     = ci_a_q;
  assign ciValueB     = ci_b_q;
  assign ciBusy       = busy_q;
  assign resp_valid   = resp_valid_q;
  assign resp_result  = result_q;
  assign resp_timeout = timeout_q;
  assign resp_latency = latency_q;
  assign err_stray    = stray_q;

endmodule
